// File: rtl/veerwolf_pkg.sv
// Shared veerwolf definitions used by the UART TX source arbiter.
//   arb_state_e      : arbiter FSM state encoding (STABLE / PENDING)
//   UART_IDLE_CYCLES : default number of consecutive high cycles that marks
//                      a UART line idle (one 11-bit frame at 115200 baud on
//                      a 50 MHz core clock)
package veerwolf_pkg;

  typedef enum logic {
    ARB_STABLE  = 1'b0,
    ARB_PENDING = 1'b1
  } arb_state_e;

  localparam int unsigned UART_IDLE_CYCLES = 4800;

endpackage

// File: rtl/uart_tx_arbiter_line_idle_cnt.sv
// line_idle_cnt: counts consecutive high cycles on a UART TX line and flags
// the line idle once the count reaches IDLE_CYCLES. The count saturates so
// an arbitrarily long idle period never wraps back to "busy".
//   i_clk  : core clock
//   i_rst  : synchronous active-high reset
//   i_line : UART TX line (idle level high)
//   o_idle : line has been high for at least IDLE_CYCLES cycles
module line_idle_cnt
  import veerwolf_pkg::*;
#(
  parameter int unsigned IDLE_CYCLES = UART_IDLE_CYCLES
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_line,
  output logic o_idle
);

  localparam int unsigned   CW      = $clog2(IDLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(IDLE_CYCLES);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else if (!i_line) begin
      cnt_q <= '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign o_idle = (cnt_q == CNT_MAX);

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: selects which of two UART TX sources drives the pin.
// A source change requested on the (asynchronous) board switch is only
// carried out once both lines have been idle for IDLE_CYCLES, so no frame
// on either source is ever cut or spliced.
//   i_clk     : core clock
//   i_rst     : synchronous active-high reset
//   i_tx0     : TX line of source 0 (CPU)
//   i_tx1     : TX line of source 1 (LiteDRAM debug)
//   i_sel     : requested source, raw switch input
//   o_tx      : registered TX line to the pin
//   o_sel     : source currently driving o_tx
//   o_pending : a requested change is waiting for both lines to go idle
//
// state   | meaning
// STABLE  | o_sel matches the request, no change outstanding
// PENDING | request differs from o_sel, waiting for both lines idle
module uart_tx_arbiter
  import veerwolf_pkg::*;
#(
  parameter int unsigned IDLE_CYCLES = UART_IDLE_CYCLES,
  parameter int unsigned SYNC_STAGES = 2   // legal range 2..4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_tx0,
  input  logic i_tx1,
  input  logic i_sel,
  output logic o_tx,
  output logic o_sel,
  output logic o_pending
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   req_sel;
  logic                   idle0;
  logic                   idle1;
  arb_state_e             state_q, state_d;
  logic                   sel_q, sel_d;
  logic                   tx_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_sel};
    end
  end

  assign req_sel = sync_q[SYNC_STAGES-1];

  line_idle_cnt #(.IDLE_CYCLES(IDLE_CYCLES)) u_idle0 (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_line (i_tx0),
    .o_idle (idle0)
  );

  line_idle_cnt #(.IDLE_CYCLES(IDLE_CYCLES)) u_idle1 (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_line (i_tx1),
    .o_idle (idle1)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ARB_STABLE;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
    end
  end

  // A withdrawn request is checked first so it wins over a coincident
  // both-idle cycle.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    case (state_q)
      ARB_STABLE: begin
        if (req_sel != sel_q) state_d = ARB_PENDING;
      end
      ARB_PENDING: begin
        if (req_sel == sel_q) begin
          state_d = ARB_STABLE;
        end else if (idle0 && idle1) begin
          state_d = ARB_STABLE;
          sel_d   = ~sel_q;
        end
      end
      default: state_d = ARB_STABLE;
    endcase
  end

  // Uses the pre-edge selection, so a switch reaches the pin one cycle
  // after o_sel changes.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tx_q <= 1'b1;
    end else begin
      tx_q <= sel_q ? i_tx1 : i_tx0;
    end
  end

  assign o_tx      = tx_q;
  assign o_sel     = sel_q;
  assign o_pending = (state_q == ARB_PENDING);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

  localparam int IDLE = 16;
  localparam int SYNC = 2;
  localparam int BIT_CYC = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tx0 = 1'b1;
  logic tx1 = 1'b1;
  logic sel = 1'b0;
  logic o_tx, o_sel, o_pend;

  int total = 0;
  int bad = 0;

  uart_tx_arbiter #(.IDLE_CYCLES(IDLE), .SYNC_STAGES(SYNC)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_tx0     (tx0),
    .i_tx1     (tx1),
    .i_sel     (sel),
    .o_tx      (o_tx),
    .o_sel     (o_sel),
    .o_pending (o_pend)
  );

  always #5 clk = ~clk;

  // Behavioural reference: high-run lengths per line as plain integers,
  // switch request seen through a SYNC-deep queue of past i_sel samples.
  logic m_tx, m_sel, m_pend, m_req;
  int   run0, run1;
  logic sel_hist[$];

  always @(posedge clk) begin
    if (rst) begin
      m_tx = 1'b1; m_sel = 1'b0; m_pend = 1'b0;
      run0 = 0; run1 = 0;
      sel_hist = {};
      for (int i = 0; i < SYNC; i++) sel_hist.push_back(1'b0);
    end else begin
      m_req = sel_hist[$];
      void'(sel_hist.pop_back());
      sel_hist.push_front(sel);
      m_tx = m_sel ? tx1 : tx0;
      if (m_pend) begin
        if (m_req == m_sel) m_pend = 1'b0;
        else if (run0 >= IDLE && run1 >= IDLE) begin
          m_sel  = ~m_sel;
          m_pend = 1'b0;
        end
      end else if (m_req != m_sel) begin
        m_pend = 1'b1;
      end
      run0 = tx0 ? run0 + 1 : 0;
      run1 = tx1 ? run1 + 1 : 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic applied;
    rst = 1'b1; tx1 = 1'b1; sel = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tx0 = i[0];
      tick();
      total++;
      if ({o_tx, o_sel, o_pend} !== 3'b100) begin
        bad++;
        $display("FAIL reset_hold cyc %0d: tx/sel/pend=%b%b%b want 100", i, o_tx, o_sel, o_pend);
      end
    end
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tx0 = 1'($urandom);
      applied = tx0;
      tick();
      total++;
      if (o_tx !== applied || o_sel !== 1'b0) begin
        bad++;
        $display("FAIL default_route cyc %0d: tx=%b sel=%b want tx=%b sel=0", i, o_tx, o_sel, applied);
      end
    end
  endtask

  task automatic test_clean_switch();
    logic applied;
    do_reset(2);
    tx0 = 1'b1; tx1 = 1'b1; sel = 1'b1;
    for (int n = 1; n <= 22; n++) begin
      tick();
      total++;
      if (o_pend !== (n >= 3 && n < 17) || o_sel !== (n >= 17)) begin
        bad++;
        $display("FAIL clean_switch n=%0d: pend=%b sel=%b want pend=%b sel=%b",
                 n, o_pend, o_sel, (n >= 3 && n < 17), (n >= 17));
      end
    end
    for (int i = 0; i < 8; i++) begin
      tx1 = 1'($urandom);
      tx0 = ~tx1;
      applied = tx1;
      tick();
      total++;
      if (o_tx !== applied) begin
        bad++;
        $display("FAIL follow_tx1 cyc %0d: tx=%b want %b", i, o_tx, applied);
      end
    end
  endtask

  task automatic test_frame_protection();
    logic [7:0] byte_v;
    logic [9:0] frame;
    logic applied;
    int   bit_idx;
    byte_v = 8'h55;
    frame  = {1'b1, byte_v, 1'b0};
    do_reset(2);
    tx0 = 1'b1; tx1 = 1'b1; sel = 1'b0;
    repeat (IDLE + 4) tick();
    sel = 1'b1;
    // stop bit first sampled at edge 9*BIT_CYC+1, switch IDLE edges later
    for (int n = 1; n <= 60; n++) begin
      bit_idx = (n - 1) / BIT_CYC;
      tx0 = (bit_idx < 10) ? frame[bit_idx] : 1'b1;
      applied = tx0;
      tick();
      total++;
      if (o_pend !== (n >= 3 && n < 9 * BIT_CYC + 1 + IDLE) ||
          o_sel !== (n >= 9 * BIT_CYC + 1 + IDLE)) begin
        bad++;
        $display("FAIL frame_protect n=%0d: pend=%b sel=%b", n, o_pend, o_sel);
      end
      if (n <= 9 * BIT_CYC + 1 + IDLE) begin
        total++;
        if (o_tx !== applied) begin
          bad++;
          $display("FAIL frame_bits n=%0d: tx=%b want %b", n, o_tx, applied);
        end
      end
    end
  endtask

  task automatic test_withdrawal();
    int cyc = 0;
    do_reset(2);
    tx0 = 1'b1; sel = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tx1 = ((cyc / 2) % 2 == 0);
      cyc++;
      tick();
    end
    for (int n = 1; n <= 20; n++) begin
      sel = (n <= 5);
      tx1 = ((cyc / 2) % 2 == 0);
      cyc++;
      tick();
      total++;
      if (o_pend !== (n >= 3 && n < 8) || o_sel !== 1'b0) begin
        bad++;
        $display("FAIL withdrawal n=%0d: pend=%b sel=%b want pend=%b sel=0",
                 n, o_pend, o_sel, (n >= 3 && n < 8));
      end
    end
  endtask

  task automatic test_simultaneous();
    do_reset(2);
    tx0 = 1'b1; tx1 = 1'b1;
    // request seen for the last time on edge 16; edge 17 sees both idle
    // together with the withdrawn request
    for (int n = 1; n <= 24; n++) begin
      sel = (n <= 14);
      tick();
      total++;
      if (o_pend !== (n >= 3 && n < 17) || o_sel !== 1'b0) begin
        bad++;
        $display("FAIL simultaneous n=%0d: pend=%b sel=%b want pend=%b sel=0",
                 n, o_pend, o_sel, (n >= 3 && n < 17));
      end
    end
  endtask

  task automatic test_reset_mid_pending();
    do_reset(2);
    tx1 = 1'b1; sel = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tx0 = i[0];
      tick();
    end
    total++;
    if (o_pend !== 1'b1) begin
      bad++;
      $display("FAIL mid_pending_setup: pend=%b want 1", o_pend);
    end
    rst = 1'b1;
    tick();
    total++;
    if ({o_tx, o_sel, o_pend} !== 3'b100) begin
      bad++;
      $display("FAIL reset_mid_pending: tx/sel/pend=%b%b%b want 100", o_tx, o_sel, o_pend);
    end
    tick();
    rst = 1'b0; tx0 = 1'b1; tx1 = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      tick();
      total++;
      if (o_pend !== (n >= 3 && n < 17) || o_sel !== (n >= 17)) begin
        bad++;
        $display("FAIL restart_switch n=%0d: pend=%b sel=%b want pend=%b sel=%b",
                 n, o_pend, o_sel, (n >= 3 && n < 17), (n >= 17));
      end
    end
  endtask

  task automatic test_random();
    int busy0 = 0;
    int busy1 = 0;
    do_reset(2);
    for (int c = 0; c < 4000; c++) begin
      if (busy0 > 0) begin tx0 = 1'($urandom); busy0--; end
      else begin tx0 = 1'b1; if ($urandom_range(49) == 0) busy0 = $urandom_range(30, 5); end
      if (busy1 > 0) begin tx1 = 1'($urandom); busy1--; end
      else begin tx1 = 1'b1; if ($urandom_range(49) == 0) busy1 = $urandom_range(30, 5); end
      if ($urandom_range(79) == 0) sel = ~sel;
      rst = ($urandom_range(999) == 0);
      tick();
      total++;
      if ({o_tx, o_sel, o_pend} !== {m_tx, m_sel, m_pend}) begin
        bad++;
        $display("FAIL random cyc %0d: tx/sel/pend=%b%b%b want %b%b%b",
                 c, o_tx, o_sel, o_pend, m_tx, m_sel, m_pend);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_clean_switch();
    test_frame_protection();
    test_withdrawal();
    test_simultaneous();
    test_reset_mid_pending();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
